gcd_job_sequencer: RTL and testbench

- Front end that drives the GCD engine's control/datapath pair from the requester side.
- Accepts operand pairs on a valid/ready interface and issues the engine's single-cycle `start` pulse.
- Drives the shared `data_in` bus with A, then B, in the exact cycles the engine loads them.
- Waits for `done`, captures the result and returns it on a valid/ready output.
- Screens zero operands, which never terminate in the subtract loop, and runs a watchdog so a hung engine cannot stall the system.

---
 rtl/gcd_job_sequencer.sv | 141 ++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
// GCD job sequencer: accepts operand pairs, drives the GCD engine's start/data_in
// handshake, waits for done under a watchdog and returns the result on a valid/ready port.
module gcd_job_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 70000,
  parameter int unsigned TO_W    = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [1:0]       out_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StLoadA, StLoadB, StWait, StDrain, StResp
  } state_e;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrZero    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

  localparam logic [TO_W-1:0] WdLimit = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  gcd_q, gcd_d;
  logic [1:0]        err_q, err_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  // Drain bookkeeping: the timeout result was taken / the late engine done was seen.
  logic              consumed_q, consumed_d;
  logic              seen_q, seen_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      gcd_q      <= '0;
      err_q      <= ErrOk;
      wd_q       <= '0;
      consumed_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gcd_q      <= gcd_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      consumed_q <= consumed_d;
      seen_q     <= seen_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    gcd_d      = gcd_q;
    err_d      = err_q;
    wd_d       = wd_q;
    consumed_d = consumed_q;
    seen_d     = seen_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          // A zero operand would spin forever in the subtract loop; answer directly.
          if (in_a == '0 || in_b == '0) begin
            gcd_d   = '0;
            err_d   = ErrZero;
            state_d = StResp;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StLoadA;
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StWait;
      StWait: begin
        wd_d = wd_q + TO_W'(1);
        if (gcd_done) begin
          gcd_d   = gcd_result;
          err_d   = ErrOk;
          state_d = StResp;
        end else if (wd_q == WdLimit) begin
          gcd_d      = '0;
          err_d      = ErrTimeout;
          consumed_d = 1'b0;
          seen_d     = 1'b0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (out_ready) consumed_d = 1'b1;
        if (gcd_done)  seen_d     = 1'b1;
        // Engine must be back in idle before the next start can be issued.
        if ((consumed_q || out_ready) && (seen_q || gcd_done)) state_d = StIdle;
      end
      StResp: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and registers only (in_ready is the sole handshake path).
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    gcd_start = (state_q == StStart);
    out_valid = (state_q == StResp) || ((state_q == StDrain) && !consumed_q);
    out_gcd   = gcd_q;
    out_err   = err_q;
    gcd_data  = '0;
    unique case (state_q)
      StStart, StLoadA: gcd_data = a_q;
      StLoadB, StWait:  gcd_data = b_q;
      default:          gcd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural subtract-loop GCD engine.
module tb_gcd_job_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gcd;
  logic [1:0]   out_err;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         busy;

  // Engine model controls: hang suppresses done, inj_done forces a one-off done.
  logic         hang = 1'b0;
  logic         inj_done = 1'b0;
  logic [W-1:0] inj_res = '0;

  int total = 0;
  int bad = 0;

  gcd_job_sequencer #(.WIDTH(W), .TIMEOUT(20), .TO_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Engine model: idle -> load A -> load B -> subtract loop -> done (one cycle).
  localparam int EIdle = 0, ELa = 1, ELb = 2, ERun = 3, EDone = 4;
  int           est = EIdle;
  logic [W-1:0] ra = '0, rb = '0;

  always @(posedge clk) begin
    if (rst) begin
      est <= EIdle;
    end else begin
      case (est)
        EIdle: if (gcd_start) est <= ELa;
        ELa: begin ra <= gcd_data; est <= ELb; end
        ELb: begin rb <= gcd_data; est <= ERun; end
        ERun: begin
          if (hang) begin
            if (inj_done) est <= EIdle;
          end else if (ra == rb) est <= EDone;
          else if (ra > rb) ra <= ra - rb;
          else rb <= rb - ra;
        end
        default: est <= EIdle;
      endcase
    end
  end

  assign gcd_done   = (est == EDone) || inj_done;
  assign gcd_result = inj_done ? inj_res : ra;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic [1:0]   e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; leaves at a negedge, idle again.
  task automatic run_vec(input vec_t v);
    bit got = 0;
    int starts = 0;
    chk("idle_ready", in_ready, 1);
    in_a = v.a; in_b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (gcd_start) starts++;
      if (v.e != 2'd1) begin
        if (k == 1) begin chk("start_pulse", gcd_start, 1); chk("data_a_start", gcd_data, v.a); end
        if (k == 2) begin chk("start_low", gcd_start, 0); chk("data_a_load", gcd_data, v.a); end
        if (k == 3) chk("data_b_load", gcd_data, v.b);
      end
      if (out_valid) begin
        got = 1;
        chk("result_gcd", out_gcd, v.g);
        chk("result_err", out_err, v.e);
        if (v.e == 2'd1) begin chk("zero_lat", k, 1); chk("zero_busy", busy, 1); end
      end
    end
    chk("result_seen", got, 1);
    chk("start_count", starts, (v.e == 2'd1) ? 0 : 1);
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int res[2];
    int nres, nacc, d1, s1, s2, k;
    bit early, got;

    vecs[0] = '{16'd48, 16'd18, 16'd6, 2'd0};
    vecs[1] = '{16'd0, 16'd25, 16'd0, 2'd1};
    vecs[2] = '{16'd25, 16'd0, 16'd0, 2'd1};
    vecs[3] = '{16'd0, 16'd0, 16'd0, 2'd1};
    vecs[4] = '{16'd100, 16'd75, 16'd25, 2'd0};
    vecs[5] = '{16'd7, 16'd13, 16'd1, 2'd0};
    vecs[6] = '{16'd65535, 16'd65535, 16'd65535, 2'd0};
    vecs[7] = '{16'd1, 16'd1, 16'd1, 2'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_gcd", out_gcd, 0);
    chk("rst_err", out_err, 0);
    chk("rst_start", gcd_start, 0);
    chk("rst_data", gcd_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back (35,35) then (17,5) with in_valid held high.
    out_ready = 1'b1; in_a = 16'd35; in_b = 16'd35; in_valid = 1'b1;
    nres = 0; nacc = 0; d1 = -1; s1 = -1; s2 = -1; early = 0;
    for (int c = 0; c < 200 && nres < 2; c++) begin
      if (gcd_start) begin if (s1 < 0) s1 = c; else s2 = c; end
      if (gcd_done && d1 < 0) d1 = c;
      if (out_valid) begin res[nres] = int'(out_gcd); nres++; end
      if (in_ready && nacc == 1 && nres == 0) early = 1;
      if (in_ready && in_valid) begin
        nacc++;
        @(posedge clk);
        #1;
        if (nacc == 1) begin in_a = 16'd17; in_b = 16'd5; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_count", nres, 2);
    chk("b2b_first", res[0], 35);
    chk("b2b_second", res[1], 1);
    chk("b2b_ready_gap", early, 0);
    chk("b2b_spacing", (s2 - d1 >= 2) && d1 >= 0 && s2 >= 0, 1);

    // Result held while out_ready is low; in_valid pulses ignored.
    @(negedge clk);
    out_ready = 1'b0; in_a = 16'd48; in_b = 16'd18; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("hold_seen", got, 1);
    in_a = 16'd9; in_b = 16'd6;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_gcd", out_gcd, 6);
      chk("hold_ready", in_ready, 0);
      in_valid = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hold_idle_ready", in_ready, 1);
    chk("hold_idle_valid", out_valid, 0);
    @(negedge clk);
    chk("hold_no_job", busy, 0);

    // Hung engine: timeout after 20 watchdog cycles, then drain.
    out_ready = 1'b0; hang = 1'b1; in_a = 16'd12; in_b = 16'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0; k = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; k = c; end
    end
    chk("to_seen", got, 1);
    chk("to_delay", (k >= 20 && k <= 25), 1);
    chk("to_err", out_err, 2);
    chk("to_gcd", out_gcd, 0);
    repeat (3) begin
      @(negedge clk);
      chk("drain_valid", out_valid, 1);
      chk("drain_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_taken", out_valid, 0);
    chk("drain_wait", in_ready, 0);
    @(negedge clk);
    chk("drain_wait2", in_ready, 0);
    inj_res = 16'd4; inj_done = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("drain_idle", in_ready, 1);
    chk("drain_idle_valid", out_valid, 0);

    // Reset during WAIT, then a fresh job.
    out_ready = 1'b1; in_a = 16'd48; in_b = 16'd18; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_gcd", out_gcd, 0);
    chk("mid_rst_err", out_err, 0);
    chk("mid_rst_start", gcd_start, 0);
    chk("mid_rst_data", gcd_data, 0);
    rst = 1'b0;
    run_vec('{16'd9, 16'd6, 16'd3, 2'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
